// File: rtl/quiz_arbiter.sv
// quiz_arbiter: four-contestant quiz buzzer arbiter with synchronized, debounced keys.
// Optional early-press foul detection is built in when FOUL_DETECT_EN is defined.
module quiz_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BEEP_CYCLES     = 25_000_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Host_Start,
  input  logic       Host_Clear,
  input  logic [3:0] Key,
  input  logic       Time_Up,
  output logic       Timer_Start,
  output logic [2:0] Winner,
  output logic [3:0] Winner_LED,
  output logic       Foul,
  output logic       Buzzer_Lock
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BEEP_W = $clog2(BEEP_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BEEP_W-1:0] BEEP_MAX  = BEEP_W'(BEEP_CYCLES);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);
  localparam int unsigned N_CH = 6;

`ifdef FOUL_DETECT_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_LOCKED  = 3'd2,
    S_EXPIRED = 3'd3,
    S_FOUL    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_LOCKED  = 3'd2,
    S_EXPIRED = 3'd3
  } state_t;
`endif

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Synchronizers hold reset values for two cycles; only then are samples real.
  logic [1:0] warm_q;
  logic [1:0] warm_d;
  logic       warm;

  always_comb begin
    warm_d = warm_q;
    if (warm_q != 2'd2) warm_d = warm_q + 2'd1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) warm_q <= 2'd0;
    else        warm_q <= warm_d;
  end

  assign warm = (warm_q == 2'd2);

  // Channel 0 = Host_Start, 1 = Host_Clear, 2..5 = Key[0..3]; all active-low.
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] press;

  assign raw = {Key, Host_Clear, Host_Start};

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      logic            sync1_q, sync2_q;
      logic            level_q, level_d;
      logic            prev_q;
      logic            qual_q, qual_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        qual_d  = qual_q;
        // A key seen low since reset must be released before it may press.
        if (warm && sync2_q) qual_d = 1'b1;
        if (sync2_q == level_q) begin
          cnt_d = '0;
        end else if (cnt_q >= DB_LAST) begin
          level_d = sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end

      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          level_q <= 1'b1;
          prev_q  <= 1'b1;
          qual_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= raw[gi];
          sync2_q <= sync1_q;
          level_q <= level_d;
          prev_q  <= level_q;
          qual_q  <= qual_d;
          cnt_q   <= cnt_d;
        end
      end

      assign press[gi] = prev_q & ~level_q & qual_q;
    end
  endgenerate

  logic       start_press, clear_press, any_key;
  logic [3:0] key_press;
  logic [2:0] pick_num;
  logic [3:0] pick_led;

  assign start_press = press[0];
  assign clear_press = press[1];
  assign key_press   = press[5:2];
  assign any_key     = |key_press;

  // Lowest-numbered key wins when several press in the same cycle.
  always_comb begin
    pick_num = 3'd0;
    pick_led = 4'd0;
    for (int i = 3; i >= 0; i--) begin
      if (key_press[i]) begin
        pick_num = 3'(i + 1);
        pick_led = 4'd1 << i;
      end
    end
  end

  state_t              state_q, state_d;
  logic                timer_q, timer_d;
  logic [2:0]          winner_q, winner_d;
  logic [3:0]          led_q, led_d;
  logic                foul_q, foul_d;
  logic                buzz_q, buzz_d;
  logic [BEEP_W-1:0]   beep_q, beep_d;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    led_d    = led_q;
    foul_d   = foul_q;
    buzz_d   = buzz_q;
    beep_d   = beep_q;
    timer_d  = 1'b0;

    if (clear_press) begin
      state_d  = S_IDLE;
      winner_d = 3'd0;
      led_d    = 4'd0;
      foul_d   = 1'b0;
      buzz_d   = 1'b0;
      beep_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_press) begin
            state_d = S_ARMED;
          end
`ifdef FOUL_DETECT_EN
          else if (any_key) begin
            state_d  = S_FOUL;
            winner_d = pick_num;
            led_d    = pick_led;
            foul_d   = 1'b1;
            buzz_d   = 1'b1;
            beep_d   = '0;
          end
`endif
        end
        S_ARMED: begin
          // A press beats a simultaneous Time_Up.
          if (any_key) begin
            state_d  = S_LOCKED;
            winner_d = pick_num;
            led_d    = pick_led;
            buzz_d   = 1'b1;
            beep_d   = '0;
          end else if (Time_Up) begin
            state_d  = S_EXPIRED;
            winner_d = 3'd0;
            led_d    = 4'd0;
          end
        end
        S_LOCKED: begin
          beep_d = (beep_q == BEEP_MAX) ? beep_q : beep_q + BEEP_W'(1);
          buzz_d = (beep_d < BEEP_MAX);
        end
        S_EXPIRED: begin
          winner_d = 3'd0;
          led_d    = 4'd0;
        end
`ifdef FOUL_DETECT_EN
        S_FOUL: begin
          if (beep_q >= BEEP_LAST) begin
            beep_d = '0;
            buzz_d = ~buzz_q;
          end else begin
            beep_d = beep_q + BEEP_W'(1);
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Registered from the next state so Timer_Start tracks the state register exactly.
    timer_d = (state_d == S_ARMED);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= 1'b0;
      winner_q <= 3'd0;
      led_q    <= 4'd0;
      foul_q   <= 1'b0;
      buzz_q   <= 1'b0;
      beep_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      winner_q <= winner_d;
      led_q    <= led_d;
      foul_q   <= foul_d;
      buzz_q   <= buzz_d;
      beep_q   <= beep_d;
    end
  end

  assign Timer_Start = timer_q;
  assign Winner      = winner_q;
  assign Winner_LED  = led_q;
  assign Foul        = foul_q;
  assign Buzzer_Lock = buzz_q;

endmodule

// File: tb/tb_quiz_arbiter.sv
// Self-checking bench for quiz_arbiter: table-driven scoreboard plus hand-written corner sequences.
// Expectations follow FOUL_DETECT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_quiz_arbiter;
  localparam int DB = 4;
  localparam int BP = 8;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Host_Start = 1'b1;
  logic       Host_Clear = 1'b1;
  logic [3:0] Key = 4'hF;
  logic       Time_Up = 1'b0;
  logic       Timer_Start;
  logic [2:0] Winner;
  logic [3:0] Winner_LED;
  logic       Foul;
  logic       Buzzer_Lock;

  always #5 CLK = ~CLK;

  quiz_arbiter #(.DEBOUNCE_CYCLES(DB), .BEEP_CYCLES(BP)) dut (
    .CLK(CLK), .RSTn(RSTn), .Host_Start(Host_Start), .Host_Clear(Host_Clear),
    .Key(Key), .Time_Up(Time_Up), .Timer_Start(Timer_Start), .Winner(Winner),
    .Winner_LED(Winner_LED), .Foul(Foul), .Buzzer_Lock(Buzzer_Lock)
  );

  typedef enum int {OP_START, OP_CLEAR, OP_KEY, OP_TIMEUP} op_t;
  typedef struct {
    op_t        op;
    logic [3:0] keys;
    int         hold;
    logic       ts;
    logic [2:0] win;
    logic [3:0] led;
    logic       foul;
  } vec_t;
  typedef struct {
    logic       ts;
    logic [2:0] win;
    logic [3:0] led;
    logic       foul;
    logic       buzz;
    logic       chk_buzz;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic chk_all(input string nm, input exp_t e);
    chk({nm, ".timer"},  int'(Timer_Start), int'(e.ts));
    chk({nm, ".winner"}, int'(Winner),      int'(e.win));
    chk({nm, ".led"},    int'(Winner_LED),  int'(e.led));
    chk({nm, ".foul"},   int'(Foul),        int'(e.foul));
    if (e.chk_buzz) chk({nm, ".buzz"}, int'(Buzzer_Lock), int'(e.buzz));
  endtask

  task automatic add(input op_t op, input logic [3:0] keys, input int hold,
                     input logic ts, input logic [2:0] win, input logic [3:0] led, input logic foul);
    vec_t v;
    v.op = op; v.keys = keys; v.hold = hold; v.ts = ts; v.win = win; v.led = led; v.foul = foul;
    tbl.push_back(v);
  endtask

  // Drive one active-low event for `hold` cycles, release it, then let debouncing settle.
  task automatic apply(input op_t op, input logic [3:0] keys, input int hold);
    @(negedge CLK);
    case (op)
      OP_START:  Host_Start = 1'b0;
      OP_CLEAR:  Host_Clear = 1'b0;
      OP_KEY:    Key = Key & ~keys;
      OP_TIMEUP: Time_Up = 1'b1;
      default:   ;
    endcase
    repeat (hold) @(negedge CLK);
    case (op)
      OP_START:  Host_Start = 1'b1;
      OP_CLEAR:  Host_Clear = 1'b1;
      OP_KEY:    Key = Key | keys;
      OP_TIMEUP: Time_Up = 1'b0;
      default:   ;
    endcase
    repeat (12) @(negedge CLK);
  endtask

  function automatic exp_t mk(input logic ts, input logic [2:0] win, input logic [3:0] led,
                              input logic foul, input logic buzz, input logic cb);
    exp_t e;
    e.ts = ts; e.win = win; e.led = led; e.foul = foul; e.buzz = buzz; e.chk_buzz = cb;
    return e;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   hi_cnt;
    bit   locked_seen;
    logic prev_ts;

    // Stimulus table: op, keys, hold cycles, expected Timer_Start/Winner/LED/Foul.
    add(OP_START,  4'b0000, 10, 1'b1, 3'd0, 4'b0000, 1'b0);
    add(OP_KEY,    4'b0100, 10, 1'b0, 3'd3, 4'b0100, 1'b0);
    add(OP_KEY,    4'b0001, 10, 1'b0, 3'd3, 4'b0100, 1'b0);
    add(OP_START,  4'b0000, 10, 1'b0, 3'd3, 4'b0100, 1'b0);
    add(OP_CLEAR,  4'b0000, 10, 1'b0, 3'd0, 4'b0000, 1'b0);
    add(OP_START,  4'b0000, 10, 1'b1, 3'd0, 4'b0000, 1'b0);
    add(OP_KEY,    4'b1010, 10, 1'b0, 3'd2, 4'b0010, 1'b0);
    add(OP_KEY,    4'b0001, 10, 1'b0, 3'd2, 4'b0010, 1'b0);
    add(OP_CLEAR,  4'b0000, 10, 1'b0, 3'd0, 4'b0000, 1'b0);
    add(OP_START,  4'b0000, 10, 1'b1, 3'd0, 4'b0000, 1'b0);
    add(OP_TIMEUP, 4'b0000, 1,  1'b0, 3'd0, 4'b0000, 1'b0);
    add(OP_KEY,    4'b0001, 10, 1'b0, 3'd0, 4'b0000, 1'b0);
    add(OP_START,  4'b0000, 10, 1'b0, 3'd0, 4'b0000, 1'b0);
    add(OP_CLEAR,  4'b0000, 10, 1'b0, 3'd0, 4'b0000, 1'b0);
    add(OP_START,  4'b0000, 10, 1'b1, 3'd0, 4'b0000, 1'b0);
    add(OP_KEY,    4'b0001, 2,  1'b1, 3'd0, 4'b0000, 1'b0);
    add(OP_CLEAR,  4'b0000, 10, 1'b0, 3'd0, 4'b0000, 1'b0);
`ifdef FOUL_DETECT_EN
    add(OP_KEY,    4'b1000, 10, 1'b0, 3'd4, 4'b1000, 1'b1);
    add(OP_START,  4'b0000, 10, 1'b0, 3'd4, 4'b1000, 1'b1);
`else
    add(OP_KEY,    4'b1000, 10, 1'b0, 3'd0, 4'b0000, 1'b0);
    add(OP_START,  4'b0000, 10, 1'b1, 3'd0, 4'b0000, 1'b0);
`endif
    add(OP_CLEAR,  4'b0000, 10, 1'b0, 3'd0, 4'b0000, 1'b0);

    // Reset state.
    repeat (3) @(negedge CLK);
    chk_all("reset", mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    RSTn = 1'b1;
    repeat (8) @(negedge CLK);
    chk_all("post_reset", mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      sb.push_back(mk(tbl[i].ts, tbl[i].win, tbl[i].led, tbl[i].foul, 1'b0, !tbl[i].foul));
      apply(tbl[i].op, tbl[i].keys, tbl[i].hold);
      e = sb.pop_front();
      $display("txn %0d op=%s keys=%b ts=%b win=%0d led=%b foul=%b buzz=%b",
               i, tbl[i].op.name(), tbl[i].keys, Timer_Start, Winner, Winner_LED, Foul, Buzzer_Lock);
      chk($sformatf("txn%0d", i), 0, 0 * int'(Winner));
      checks--;
      chk_all($sformatf("txn%0d", i), e);
    end

    // Lock timing: Timer_Start drops with lock entry, beep lasts exactly BP cycles.
    apply(OP_START, 4'b0000, 10);
    @(negedge CLK);
    Key = 4'b1011;
    hi_cnt = 0;
    locked_seen = 1'b0;
    prev_ts = Timer_Start;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (!locked_seen && Winner != 3'd0) begin
        locked_seen = 1'b1;
        chk("lock_prev_timer", int'(prev_ts), 1);
        chk("lock_timer", int'(Timer_Start), 0);
        chk("lock_winner", int'(Winner), 3);
        chk("lock_led", int'(Winner_LED), 4);
        chk("lock_buzz_first", int'(Buzzer_Lock), 1);
      end
      if (Buzzer_Lock) hi_cnt++;
      prev_ts = Timer_Start;
    end
    chk("lock_seen", int'(locked_seen), 1);
    chk("beep_len", hi_cnt, BP);
    $display("txn beep: winner=%0d beep_cycles=%0d", Winner, hi_cnt);
    Key = 4'hF;
    apply(OP_CLEAR, 4'b0000, 10);

    // Press and Time_Up in the same ARMED cycle: press reaches the FSM six edges after the key falls.
    apply(OP_START, 4'b0000, 10);
    @(negedge CLK);
    Key = 4'b1110;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    Time_Up = 1'b1;
    @(negedge CLK);
    Time_Up = 1'b0;
    repeat (4) @(negedge CLK);
    $display("txn tie: ts=%b winner=%0d", Timer_Start, Winner);
    chk("tie_winner", int'(Winner), 1);
    chk("tie_led", int'(Winner_LED), 1);
    chk("tie_timer", int'(Timer_Start), 0);
    Key = 4'hF;
    apply(OP_CLEAR, 4'b0000, 10);

    // Reset mid-lock with Key[0] held through release.
    apply(OP_START, 4'b0000, 10);
    @(negedge CLK);
    Key = 4'b1110;
    locked_seen = 1'b0;
    for (int c = 0; c < 20 && !locked_seen; c++) begin
      @(negedge CLK);
      if (Buzzer_Lock) locked_seen = 1'b1;
    end
    chk("rst_buzz_seen", int'(locked_seen), 1);
    #2 RSTn = 1'b0;
    #1;
    chk_all("rst_async", mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (10) @(negedge CLK);
    chk_all("rst_idle", mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    apply(OP_START, 4'b0000, 10);
    $display("txn held_key_after_reset: ts=%b winner=%0d", Timer_Start, Winner);
    chk_all("rst_held_key", mk(1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    Key = 4'hF;
    repeat (12) @(negedge CLK);
    apply(OP_KEY, 4'b0001, 10);
    $display("txn repress: ts=%b winner=%0d", Timer_Start, Winner);
    chk_all("rst_repress", mk(1'b0, 3'd1, 4'd1, 1'b0, 1'b0, 1'b1));
    apply(OP_CLEAR, 4'b0000, 10);
    chk_all("final_clear", mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
